reg_scoreboard: RTL and testbench

//  Register-dependency scoreboard for the LC-3b pipeline, the retire-side counterpart of the bubble-inserting hazard unit.

---
 rtl/reg_scoreboard_pkg.sv | 40 ++++
 rtl/reg_scoreboard_if.sv | 26 ++
 rtl/reg_scoreboard_sb_operand_decode.sv | 79 +++++++
 rtl/reg_scoreboard.sv | 120 ++++++++++++
 tb/tb_reg_scoreboard.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Purpose : shared types and constants for the LC-3b register-dependency
//           scoreboard (register index, 9-entry scoreboard mask, opcodes).
// Ports   : none (package).
package reg_scoreboard_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [8:0]  sb_mask;

  // Entries 0..7 are R0..R7, entry 8 tracks the condition codes.
  localparam int     SB_CC_IDX  = 8;
  localparam int     SB_ENTRIES = 9;
  localparam sb_mask SB_CC_BIT  = 9'b1_0000_0000;
  localparam sb_mask SB_R7_BIT  = 9'b0_1000_0000;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LDB  = 4'h2,
    OP_STB  = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_SHF  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } lc3b_opcode;

  // One-hot scoreboard mask selecting a general-purpose register.
  function automatic sb_mask reg_bit(input lc3b_reg r);
    return sb_mask'(9'd1 << r);
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Purpose : decode/issue handshake and writeback bus of the scoreboard.
// Signals : dec_ir, pipe_stall (decode side), wb_valid/wb_dest/wb_cc
//           (writeback side), raw_stall/issue (scoreboard responses).
// Modports: master = pipeline driving the scoreboard, slave = scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  lc3b_word dec_ir;
  logic     pipe_stall;
  logic     wb_valid;
  lc3b_reg  wb_dest;
  logic     wb_cc;
  logic     raw_stall;
  logic     issue;

  modport master (
    output dec_ir, pipe_stall, wb_valid, wb_dest, wb_cc,
    input  raw_stall, issue
  );

  modport slave (
    input  dec_ir, pipe_stall, wb_valid, wb_dest, wb_cc,
    output raw_stall, issue
  );

endinterface

// File: rtl/reg_scoreboard_sb_operand_decode.sv
// Purpose : combinational operand decode of the instruction in decode.
// Ports   : i_dec_ir     instruction word (16'h0000 = bubble)
//           o_src_mask   scoreboard entries read by the instruction
//           o_dst_mask   scoreboard entries written by the instruction
//           o_is_bubble  instruction is the all-zero bubble
module sb_operand_decode
  import reg_scoreboard_pkg::*;
(
  input  lc3b_word i_dec_ir,
  output sb_mask   o_src_mask,
  output sb_mask   o_dst_mask,
  output logic     o_is_bubble
);

  lc3b_opcode w_op;
  sb_mask     w_src;
  sb_mask     w_dst;

  assign w_op = lc3b_opcode'(i_dec_ir[15:12]);

  // Source/destination masks from the opcode and register fields.
  always_comb begin
    w_src = 9'b0;
    w_dst = 9'b0;
    case (w_op)
      OP_ADD, OP_AND: begin
        w_src = reg_bit(i_dec_ir[8:6]);
        if (!i_dec_ir[5]) begin
          w_src = w_src | reg_bit(i_dec_ir[2:0]);
        end else begin
          w_src = w_src;
        end
        w_dst = reg_bit(i_dec_ir[11:9]) | SB_CC_BIT;
      end
      OP_NOT, OP_LDR, OP_LDB, OP_LDI: begin
        w_src = reg_bit(i_dec_ir[8:6]);
        w_dst = reg_bit(i_dec_ir[11:9]) | SB_CC_BIT;
      end
      OP_LEA: begin
        w_dst = reg_bit(i_dec_ir[11:9]) | SB_CC_BIT;
      end
      OP_STR, OP_STB, OP_STI: begin
        w_src = reg_bit(i_dec_ir[8:6]) | reg_bit(i_dec_ir[11:9]);
      end
      OP_JMP: begin
        w_src = reg_bit(i_dec_ir[8:6]);
      end
      OP_JSR: begin
        // ir[11]=0 is JSRR, which reads its base register; JSR reads nothing.
        if (!i_dec_ir[11]) begin
          w_src = reg_bit(i_dec_ir[8:6]);
        end else begin
          w_src = 9'b0;
        end
        w_dst = SB_R7_BIT;
      end
      OP_TRAP: begin
        w_dst = SB_R7_BIT;
      end
      OP_BR: begin
        // An unconditional-never branch (nzp=000, including the bubble) has no CC use.
        if (i_dec_ir[11:9] != 3'b000) begin
          w_src = SB_CC_BIT;
        end else begin
          w_src = 9'b0;
        end
      end
      default: begin
        w_src = 9'b0;
        w_dst = 9'b0;
      end
    endcase
  end

  assign o_src_mask  = w_src;
  assign o_dst_mask  = w_dst;
  assign o_is_bubble = (i_dec_ir == 16'h0000);

endmodule

// File: rtl/reg_scoreboard.sv
// Purpose : register-dependency scoreboard. Tracks in-flight writers per
//           register/CC, holds decode on RAW hazards or writer-count
//           saturation, and counts stall/issue activity.
// Ports   : clk, rst_n (synchronous, active-low)
//           sb_if            decode/writeback bus (slave modport)
//           o_stall_cycles   cycles with raw_stall asserted (wraps)
//           o_issued_cnt     non-bubble instructions issued (wraps)
//           o_err_underflow  sticky: writeback to an entry with no writer
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_scoreboard_if.slave   sb_if,
  output logic [PERF_W-1:0] o_stall_cycles,
  output logic [PERF_W-1:0] o_issued_cnt,
  output logic              o_err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0]  r_pend [SB_ENTRIES];
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_issued_cnt;
  logic              r_err_underflow;

  sb_mask           w_src;
  sb_mask           w_dst;
  logic             w_is_bubble;
  sb_mask           w_wb_hit;
  sb_mask           w_pend_nz;
  sb_mask           w_retire;
  sb_mask           w_eff_nz;
  sb_mask           w_eff_max;
  sb_mask           w_inc;
  logic [CNT_W-1:0] w_eff [SB_ENTRIES];
  logic             w_raw_stall;
  logic             w_issue;
  logic             w_underflow;

  sb_operand_decode u_decode (
    .i_dec_ir   (sb_if.dec_ir),
    .o_src_mask (w_src),
    .o_dst_mask (w_dst),
    .o_is_bubble(w_is_bubble)
  );

  // Entries hit by this cycle's writeback (register and/or CC).
  always_comb begin
    w_wb_hit = 9'b0;
    if (sb_if.wb_valid) begin
      w_wb_hit = reg_bit(sb_if.wb_dest);
      w_wb_hit[SB_CC_IDX] = sb_if.wb_cc;
    end else begin
      w_wb_hit = 9'b0;
    end
  end

  // Effective pending count: a same-cycle retire already counts as resolved
  // because the register file writes before it reads.
  always_comb begin
    w_pend_nz = 9'b0;
    w_retire  = 9'b0;
    w_eff_nz  = 9'b0;
    w_eff_max = 9'b0;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      w_pend_nz[i] = (r_pend[i] != CNT_ZERO);
      w_retire[i]  = w_wb_hit[i] & w_pend_nz[i];
      w_eff[i]     = r_pend[i] - CNT_W'(w_retire[i]);
      w_eff_nz[i]  = (w_eff[i] != CNT_ZERO);
      w_eff_max[i] = (w_eff[i] == CNT_MAX);
    end
  end

  // Hold decode on a pending source or on a destination whose writer count
  // cannot take another increment.
  always_comb begin
    w_raw_stall = (|(w_src & w_eff_nz)) | (|(w_dst & w_eff_max));
    w_issue     = ~w_raw_stall & ~sb_if.pipe_stall;
    w_inc       = w_issue ? w_dst : 9'b0;
    w_underflow = |(w_wb_hit & ~w_pend_nz);
  end

  // Per-entry in-flight writer counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_ENTRIES; i++) begin
        r_pend[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < SB_ENTRIES; i++) begin
        r_pend[i] <= r_pend[i] + CNT_W'(w_inc[i]) - CNT_W'(w_retire[i]);
      end
    end
  end

  // Performance counters and the sticky underflow flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles  <= {PERF_W{1'b0}};
      r_issued_cnt    <= {PERF_W{1'b0}};
      r_err_underflow <= 1'b0;
    end else begin
      r_stall_cycles  <= r_stall_cycles + PERF_W'(w_raw_stall);
      r_issued_cnt    <= r_issued_cnt + PERF_W'(w_issue & ~w_is_bubble);
      r_err_underflow <= r_err_underflow | w_underflow;
    end
  end

  assign sb_if.raw_stall = w_raw_stall;
  assign sb_if.issue     = w_issue;
  assign o_stall_cycles  = r_stall_cycles;
  assign o_issued_cnt    = r_issued_cnt;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Purpose : self-checking bench for reg_scoreboard. Directed scenarios plus
//           randomized traffic, all checked against a count-per-entry model.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [15:0] stall_cycles;
  logic [15:0] issued_cnt;
  logic        err_underflow;

  reg_scoreboard_if sb_if ();

  reg_scoreboard #(.CNT_W(2), .PERF_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sb_if          (sb_if),
    .o_stall_cycles (stall_cycles),
    .o_issued_cnt   (issued_cnt),
    .o_err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: writers in flight per entry (0..7 = R0..R7, 8 = CC).
  int m_pend [9];
  int m_stall_cycles;
  int m_issued;
  bit m_err;
  bit exp_stall;
  bit exp_issue;

  // Operand table straight from the ISA rules.
  function automatic void model_decode(input logic [15:0] ir,
                                       output bit [8:0] s, output bit [8:0] d);
    int op;
    op = int'(ir[15:12]);
    s = 9'b0;
    d = 9'b0;
    case (op)
      1, 5: begin
        s[ir[8:6]] = 1'b1;
        if (ir[5] == 1'b0) s[ir[2:0]] = 1'b1;
        d[ir[11:9]] = 1'b1; d[8] = 1'b1;
      end
      9, 6, 2, 10: begin
        s[ir[8:6]] = 1'b1;
        d[ir[11:9]] = 1'b1; d[8] = 1'b1;
      end
      14: begin d[ir[11:9]] = 1'b1; d[8] = 1'b1; end
      3, 7, 11: begin s[ir[8:6]] = 1'b1; s[ir[11:9]] = 1'b1; end
      12: s[ir[8:6]] = 1'b1;
      4: begin
        if (ir[11] == 1'b0) s[ir[8:6]] = 1'b1;
        d[7] = 1'b1;
      end
      15: d[7] = 1'b1;
      0: if (ir[11:9] != 3'b000) s[8] = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic bit wb_hits(input int x);
    if (!sb_if.wb_valid) return 1'b0;
    if (x == 8) return sb_if.wb_cc;
    return (int'(sb_if.wb_dest) == x);
  endfunction

  task automatic model_eval();
    bit [8:0] s;
    bit [8:0] d;
    int eff;
    model_decode(sb_if.dec_ir, s, d);
    exp_stall = 1'b0;
    for (int x = 0; x < 9; x++) begin
      eff = m_pend[x] - ((wb_hits(x) && m_pend[x] > 0) ? 1 : 0);
      if (s[x] && eff != 0) exp_stall = 1'b1;
      if (d[x] && eff == 3) exp_stall = 1'b1;
    end
    exp_issue = !exp_stall && !sb_if.pipe_stall;
  endtask

  // One clock: model follows the DUT across the rising edge.
  task automatic advance();
    bit [8:0] s;
    bit [8:0] d;
    bit hit;
    bit [15:0] ir;
    model_eval();
    model_decode(sb_if.dec_ir, s, d);
    ir = sb_if.dec_ir;
    @(posedge clk);
    if (!rst_n) begin
      for (int x = 0; x < 9; x++) m_pend[x] = 0;
      m_stall_cycles = 0;
      m_issued = 0;
      m_err = 1'b0;
    end else begin
      for (int x = 0; x < 9; x++) begin
        hit = wb_hits(x);
        if (hit && m_pend[x] == 0) m_err = 1'b1;
        m_pend[x] = m_pend[x] + ((exp_issue && d[x]) ? 1 : 0)
                              - ((hit && m_pend[x] > 0) ? 1 : 0);
      end
      m_stall_cycles = (m_stall_cycles + (exp_stall ? 1 : 0)) % 65536;
      if (exp_issue && ir != 16'h0000) m_issued = (m_issued + 1) % 65536;
    end
    #1;
  endtask

  task automatic drive(input logic [15:0] ir, input logic ps, input logic wv,
                       input logic [2:0] wd, input logic wc);
    sb_if.dec_ir     = ir;
    sb_if.pipe_stall = ps;
    sb_if.wb_valid   = wv;
    sb_if.wb_dest    = wd;
    sb_if.wb_cc      = wc;
    #1;
    model_eval();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    advance();
    advance();
    rst_n = 1'b1;
    drive(16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b01) begin
      n_errors++;
      $display("FAIL reset_issue: got stall/issue=%b%b expected 01", sb_if.raw_stall, sb_if.issue);
    end
    n_checks++;
    if ({stall_cycles, issued_cnt, err_underflow} !== 33'd0) begin
      n_errors++;
      $display("FAIL reset_state: got stall_cycles=%0d issued=%0d err=%b expected 0 0 0",
               stall_cycles, issued_cnt, err_underflow);
    end
    drive(16'h0000, 1'b1, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (sb_if.issue !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_pipe_stall: got issue=%b expected 0", sb_if.issue);
    end
  endtask

  task automatic test_raw_add();
    drive(16'h1283, 1'b0, 1'b0, 3'd0, 1'b0);  // ADD R1,R2,R3
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b01 || exp_issue !== 1'b1) begin
      n_errors++;
      $display("FAIL add_issue: got stall/issue=%b%b expected 01", sb_if.raw_stall, sb_if.issue);
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(16'h1862, 1'b0, 1'b0, 3'd0, 1'b0);  // ADD R4,R1,#2 depends on R1
      n_checks++;
      if ({sb_if.raw_stall, sb_if.issue} !== 2'b10 || exp_stall !== 1'b1) begin
        n_errors++;
        $display("FAIL raw_hold: cycle %0d got stall/issue=%b%b expected 10", k, sb_if.raw_stall, sb_if.issue);
      end
      advance();
    end
    drive(16'h1862, 1'b0, 1'b1, 3'd1, 1'b1);  // R1 retires this cycle
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b01) begin
      n_errors++;
      $display("FAIL raw_release: got stall/issue=%b%b expected 01", sb_if.raw_stall, sb_if.issue);
    end
    advance();
    drive(16'h0000, 1'b0, 1'b1, 3'd4, 1'b1);
    advance();
    n_checks++;
    if (stall_cycles !== 16'd2 || issued_cnt !== 16'd2 || m_issued != 2) begin
      n_errors++;
      $display("FAIL raw_counters: got stall_cycles=%0d issued=%0d expected 2 2", stall_cycles, issued_cnt);
    end
  endtask

  task automatic test_cc_branch();
    drive(16'h6080, 1'b0, 1'b0, 3'd0, 1'b0);  // LDR R0,R2,#0
    advance();
    for (int k = 0; k < 2; k++) begin
      drive(16'h0402, 1'b0, 1'b0, 3'd0, 1'b0);  // BRz waits on CC
      n_checks++;
      if (sb_if.raw_stall !== 1'b1) begin
        n_errors++;
        $display("FAIL brz_hold: cycle %0d got stall=%b expected 1", k, sb_if.raw_stall);
      end
      advance();
    end
    drive(16'h0402, 1'b0, 1'b1, 3'd0, 1'b1);
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b01) begin
      n_errors++;
      $display("FAIL brz_release: got stall/issue=%b%b expected 01", sb_if.raw_stall, sb_if.issue);
    end
    advance();
    drive(16'h16A0, 1'b0, 1'b0, 3'd0, 1'b0);  // ADD R3 makes CC pending
    advance();
    drive(16'h0000, 1'b0, 1'b0, 3'd0, 1'b0);  // never-taken BR
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b01) begin
      n_errors++;
      $display("FAIL br_never: got stall/issue=%b%b expected 01", sb_if.raw_stall, sb_if.issue);
    end
    advance();
    drive(16'h0000, 1'b0, 1'b1, 3'd3, 1'b1);
    advance();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      drive(16'h1AA0, 1'b0, 1'b0, 3'd0, 1'b0);  // ADD R5,R2,#0
      n_checks++;
      if (sb_if.issue !== 1'b1) begin
        n_errors++;
        $display("FAIL sat_fill: writer %0d got issue=%b expected 1", k, sb_if.issue);
      end
      advance();
    end
    drive(16'h1AA0, 1'b0, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b10 || m_pend[5] != 3) begin
      n_errors++;
      $display("FAIL sat_stall: got stall/issue=%b%b expected 10", sb_if.raw_stall, sb_if.issue);
    end
    advance();
    for (int k = 0; k < 3; k++) begin
      drive(16'h0000, 1'b0, 1'b1, 3'd5, 1'b1);
      advance();
    end
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_drain_err: got err=%b expected 0", err_underflow);
    end
  endtask

  task automatic test_same_cycle();
    drive(16'h1CA0, 1'b0, 1'b0, 3'd0, 1'b0);  // ADD R6,R2,#0
    advance();
    drive(16'h1CA0, 1'b0, 1'b1, 3'd6, 1'b1);  // issue and retire R6 together
    n_checks++;
    if (sb_if.issue !== 1'b1) begin
      n_errors++;
      $display("FAIL same_cycle_issue: got issue=%b expected 1", sb_if.issue);
    end
    advance();
    drive(16'h19A1, 1'b0, 1'b0, 3'd0, 1'b0);  // reads R6, still one writer
    n_checks++;
    if (sb_if.raw_stall !== 1'b1 || m_pend[6] != 1) begin
      n_errors++;
      $display("FAIL same_cycle_pend: got stall=%b expected 1", sb_if.raw_stall);
    end
    drive(16'h0000, 1'b0, 1'b1, 3'd2, 1'b0);  // R2 has no writer
    advance();
    n_checks++;
    if (err_underflow !== 1'b1 || m_err !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow: got err=%b expected 1", err_underflow);
    end
  endtask

  task automatic test_reset_mid();
    drive(16'h19A1, 1'b0, 1'b0, 3'd0, 1'b0);
    advance();
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    drive(16'h19A1, 1'b0, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b01) begin
      n_errors++;
      $display("FAIL midreset_stall: got stall/issue=%b%b expected 01", sb_if.raw_stall, sb_if.issue);
    end
    n_checks++;
    if ({stall_cycles, issued_cnt, err_underflow} !== 33'd0) begin
      n_errors++;
      $display("FAIL midreset_state: got stall_cycles=%0d issued=%0d err=%b expected 0 0 0",
               stall_cycles, issued_cnt, err_underflow);
    end
    advance();
  endtask

  task automatic test_pipe_stall();
    drive(16'h1283, 1'b1, 1'b0, 3'd0, 1'b0);  // blocked: R1 must not be marked
    n_checks++;
    if ({sb_if.raw_stall, sb_if.issue} !== 2'b00) begin
      n_errors++;
      $display("FAIL pstall_block: got stall/issue=%b%b expected 00", sb_if.raw_stall, sb_if.issue);
    end
    advance();
    drive(16'h1862, 1'b0, 1'b0, 3'd0, 1'b0);
    n_checks++;
    if (sb_if.raw_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL pstall_no_mark: got stall=%b expected 0", sb_if.raw_stall);
    end
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      drive(16'($urandom), ($urandom_range(3) == 0), 1'($urandom),
            3'($urandom), 1'($urandom));
      n_checks++;
      if ({sb_if.raw_stall, sb_if.issue} !== {exp_stall, exp_issue}) begin
        n_errors++;
        $display("FAIL rand_hazard: cycle %0d ir=%h got stall/issue=%b%b expected %b%b",
                 k, sb_if.dec_ir, sb_if.raw_stall, sb_if.issue, exp_stall, exp_issue);
      end
      advance();
      n_checks++;
      if (stall_cycles !== 16'(m_stall_cycles) || issued_cnt !== 16'(m_issued) ||
          err_underflow !== m_err) begin
        n_errors++;
        $display("FAIL rand_counters: cycle %0d got %0d/%0d/%b expected %0d/%0d/%b",
                 k, stall_cycles, issued_cnt, err_underflow, m_stall_cycles, m_issued, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw_add();
    test_cc_branch();
    test_saturation();
    test_same_cycle();
    test_reset_mid();
    test_pipe_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
